// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide over 32 iterations.
// Signed operations run on operand magnitudes and are sign-corrected in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation of a single-width word.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a word; the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic             r_op_div;     // 1: divide, 0: multiply
    logic             r_op_signed;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_mag;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_acc_hi;     // partial product high / partial remainder
    logic [WIDTH-1:0] r_acc_lo;     // multiplier / dividend-quotient shifter
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_acc_hi_nxt;
    logic [WIDTH-1:0]   w_acc_lo_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_sign_diff;

    assign w_mul_sum   = {1'b0, r_acc_hi} + {1'b0, r_mag};
    assign w_trial     = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff      = w_trial - {1'b0, r_mag};
    assign w_sign_diff = r_op_signed & (r_sign_a ^ r_sign_b);

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        if (r_op_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_hi_nxt = w_diff[WIDTH-1:0];
                w_acc_lo_nxt = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_hi_nxt = w_trial[WIDTH-1:0];
                w_acc_lo_nxt = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_acc_lo[0]) begin
                w_acc_hi_nxt = w_mul_sum[WIDTH:1];
                w_acc_lo_nxt = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
            end else begin
                w_acc_hi_nxt = {1'b0, r_acc_hi[WIDTH-1:1]};
                w_acc_lo_nxt = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up applied to the raw magnitude results in FIX.
    always_comb begin
        w_prod_fix = {r_acc_hi, r_acc_lo};
        w_quo_fix  = r_acc_lo;
        w_rem_fix  = r_acc_hi;
        if (w_sign_diff) begin
            w_prod_fix = f_neg2({r_acc_hi, r_acc_lo});
            w_quo_fix  = f_neg(r_acc_lo);
        end else begin
            w_prod_fix = {r_acc_hi, r_acc_lo};
            w_quo_fix  = r_acc_lo;
        end
        if (r_op_signed && r_sign_a) begin
            w_rem_fix = f_neg(r_acc_hi);
        end else begin
            w_rem_fix = r_acc_hi;
        end
    end

    // Control FSM with operand capture, iteration and HI/LO write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 5'd0;
            r_op_div    <= 1'b0;
            r_op_signed <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_mag       <= {WIDTH{1'b0}};
            r_acc_hi    <= {WIDTH{1'b0}};
            r_acc_lo    <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= {WIDTH{1'b0}};
            r_lo        <= {WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_op_div    <= op[1];
                                r_op_signed <= ~op[0];
                                r_sign_a    <= opa[WIDTH-1] & ~op[0];
                                r_sign_b    <= opb[WIDTH-1] & ~op[0];
                                // Divide keeps the divisor; multiply keeps the multiplicand.
                                r_mag       <= op[1] ? (op[0] ? opb : f_abs(opb))
                                                     : (op[0] ? opa : f_abs(opa));
                                r_acc_lo    <= op[1] ? (op[0] ? opa : f_abs(opa))
                                                     : (op[0] ? opb : f_abs(opb));
                                r_acc_hi    <= {WIDTH{1'b0}};
                                r_cnt       <= 5'd0;
                                r_busy      <= 1'b1;
                                r_state     <= ST_CALC;
                            end
                            OP_MTHI: r_hi <= opa;
                            OP_MTLO: r_lo <= opa;
                            default: ;
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc_hi <= w_acc_hi_nxt;
                        r_acc_lo <= w_acc_lo_nxt;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_op_div) begin
                            if (r_mag == {WIDTH{1'b0}}) begin
                                r_dbz <= 1'b1;
                            end else begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end else begin
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
